// File: rtl/gcm_seq.sv
// gcm_seq: message sequencer driving the gcm core strobe interface.
// Converts a typed valid/ready block stream (IV/AAD/DATA + last) into
// registered gcm_*_vld / gcm_end pulses, enforces message ordering, and
// closes each message by waiting for the core tag and checking that
// every issued AAD/DATA block produced a core data-valid.
module gcm_seq #(
    parameter int unsigned IV_GAP   = 1,
    parameter int unsigned TAG_TO   = 64,
    parameter int unsigned KEY_WAIT = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_vld_i,
    input  logic [127:0] key_i,
    input  logic         s_vld_i,
    output logic         s_rdy_o,
    input  logic [1:0]   s_type_i,
    input  logic         s_last_i,
    input  logic [127:0] s_data_i,
    output logic         gcm_key_vld_o,
    output logic [127:0] gcm_key_o,
    output logic         gcm_iv_vld_o,
    output logic         gcm_aad_vld_o,
    output logic         gcm_data_vld_o,
    output logic         gcm_end_o,
    output logic [127:0] gcm_data_o,
    input  logic         gcm_dvld_i,
    input  logic         gcm_tag_vld_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam int unsigned KW = $clog2(KEY_WAIT + 2);
    localparam int unsigned GW = $clog2(IV_GAP + 2);
    localparam int unsigned TW = $clog2(TAG_TO + 2);

    localparam logic [1:0] TYPE_IV   = 2'b00;
    localparam logic [1:0] TYPE_AAD  = 2'b01;
    localparam logic [1:0] TYPE_DATA = 2'b10;
    localparam logic [1:0] TYPE_RSV  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IV_GAP,
        S_AAD,
        S_DATA,
        S_END,
        S_WAIT_TAG
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic            key_ok;
    logic [KW-1:0]   key_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            iv_last;
    logic [TW-1:0]   to_cnt;
    logic [15:0]     in_cnt;
    logic [15:0]     out_cnt;

    logic            accept;
    logic            is_iv;
    logic            is_aad;
    logic            is_data;
    logic            is_rsv;
    logic            tag_match;
    logic            tag_expire;
    logic            gap_done;

    logic            key_nx;
    logic            iv_nx;
    logic            aad_nx;
    logic            data_nx;
    logic            end_nx;
    logic            done_nx;
    logic            err_nx;

    // Upstream ready is a pure function of state and key readiness
    always_comb begin
        case (state)
            S_IDLE:        s_rdy_o = key_ok;
            S_AAD, S_DATA: s_rdy_o = 1'b1;
            default:       s_rdy_o = 1'b0;
        endcase
    end

    assign accept     = s_vld_i & s_rdy_o;
    assign is_iv      = accept & (s_type_i == TYPE_IV);
    assign is_aad     = accept & (s_type_i == TYPE_AAD);
    assign is_data    = accept & (s_type_i == TYPE_DATA);
    assign is_rsv     = accept & (s_type_i == TYPE_RSV);
    assign busy_o     = (state != S_IDLE);
    assign tag_match  = (out_cnt == in_cnt);
    assign tag_expire = (to_cnt <= TW'(1));
    // Leaving at count<=1 makes exactly IV_GAP idle cycles follow the IV strobe
    assign gap_done   = (gap_cnt <= GW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: ordering rules, aborts and message completion
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (is_iv) state_nx = S_IV_GAP;
            end
            S_IV_GAP: begin
                if (gap_done) state_nx = iv_last ? S_END : S_AAD;
            end
            S_AAD: begin
                if (is_iv)        state_nx = S_IDLE;
                else if (is_aad)  state_nx = s_last_i ? S_END : S_AAD;
                else if (is_data) state_nx = s_last_i ? S_END : S_DATA;
            end
            S_DATA: begin
                if (is_iv || is_aad)       state_nx = S_IDLE;
                else if (is_data && s_last_i) state_nx = S_END;
            end
            S_END: begin
                state_nx = S_WAIT_TAG;
            end
            S_WAIT_TAG: begin
                if (gcm_tag_vld_i || tag_expire) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode: next values of the registered strobes and status pulses
    always_comb begin
        key_nx  = (state == S_IDLE) & key_vld_i;
        iv_nx   = (state == S_IDLE) & is_iv;
        aad_nx  = (state == S_AAD) & is_aad;
        data_nx = ((state == S_AAD) | (state == S_DATA)) & is_data;
        end_nx  = (state == S_END);
        done_nx = (state == S_WAIT_TAG) & gcm_tag_vld_i & tag_match;
        err_nx  = 1'b0;
        if (key_vld_i && (state != S_IDLE))                 err_nx = 1'b1;
        if (is_rsv)                                         err_nx = 1'b1;
        if ((state == S_IDLE) && accept && !is_iv)          err_nx = 1'b1;
        if ((state == S_AAD) && is_iv)                      err_nx = 1'b1;
        if ((state == S_DATA) && (is_iv || is_aad))         err_nx = 1'b1;
        if (state == S_WAIT_TAG) begin
            if (gcm_tag_vld_i) err_nx = !tag_match;
            else if (tag_expire) err_nx = 1'b1;
        end
    end

    // Output register: one-cycle strobes, payload and key hold between strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gcm_key_vld_o  <= 1'b0;
            gcm_key_o      <= '0;
            gcm_iv_vld_o   <= 1'b0;
            gcm_aad_vld_o  <= 1'b0;
            gcm_data_vld_o <= 1'b0;
            gcm_end_o      <= 1'b0;
            gcm_data_o     <= '0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            gcm_key_vld_o  <= key_nx;
            gcm_iv_vld_o   <= iv_nx;
            gcm_aad_vld_o  <= aad_nx;
            gcm_data_vld_o <= data_nx;
            gcm_end_o      <= end_nx;
            done_o         <= done_nx;
            err_o          <= err_nx;
            if (key_nx) gcm_key_o <= key_i;
            if (iv_nx || aad_nx || data_nx) gcm_data_o <= s_data_i;
        end
    end

    // Key expansion wait: key_ok rises once the counter runs down to zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_ok  <= 1'b0;
            key_cnt <= '0;
        end else if (key_nx) begin
            key_cnt <= KW'(KEY_WAIT);
            key_ok  <= (KEY_WAIT == 0);
        end else if (key_cnt != '0) begin
            key_cnt <= key_cnt - KW'(1);
            if (key_cnt == KW'(1)) key_ok <= 1'b1;
        end
    end

    // IV gap counter and empty-message flag captured with the IV
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt <= '0;
            iv_last <= 1'b0;
        end else if (iv_nx) begin
            gap_cnt <= GW'(IV_GAP);
            iv_last <= s_last_i;
        end else if ((state == S_IV_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    // Tag timeout: loaded in END, runs down while waiting for the tag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == S_END) begin
            to_cnt <= TW'(TAG_TO);
        end else if ((state == S_WAIT_TAG) && (to_cnt != '0)) begin
            to_cnt <= to_cnt - TW'(1);
        end
    end

    // Issued-block and returned-data counters, cleared at each new IV
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (iv_nx) in_cnt <= '0;
            else if (aad_nx || data_nx) in_cnt <= in_cnt + 16'd1;
            if (iv_nx) out_cnt <= '0;
            else if ((state != S_IDLE) && gcm_dvld_i) out_cnt <= out_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gcm_seq.sv
// tb_gcm_seq: randomized message bench for gcm_seq with an event-level
// reference model of the expected strobe/status sequence.
module tb_gcm_seq;

    localparam int unsigned IV_GAP   = 1;
    localparam int unsigned TAG_TO   = 64;
    localparam int unsigned KEY_WAIT = 12;

    localparam int K_KEY = 0, K_IV = 1, K_AAD = 2, K_DATA = 3, K_END = 4, K_DONE = 5, K_ERR = 6;

    typedef struct {
        int           kind;
        logic [127:0] data;
        int           cyc;
    } ev_t;

    typedef struct {
        logic [1:0]   typ;
        logic         last;
        logic [127:0] data;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_vld_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         s_vld_i = 1'b0;
    logic         s_rdy_o;
    logic [1:0]   s_type_i = '0;
    logic         s_last_i = 1'b0;
    logic [127:0] s_data_i = '0;
    logic         gcm_key_vld_o;
    logic [127:0] gcm_key_o;
    logic         gcm_iv_vld_o;
    logic         gcm_aad_vld_o;
    logic         gcm_data_vld_o;
    logic         gcm_end_o;
    logic [127:0] gcm_data_o;
    logic         gcm_dvld_i = 1'b0;
    logic         gcm_tag_vld_i = 1'b0;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    ev_t  ev_q[$];
    ev_t  exp_q[$];
    blk_t msg_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   log_en = 1'b0;

    gcm_seq #(.IV_GAP(IV_GAP), .TAG_TO(TAG_TO), .KEY_WAIT(KEY_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .key_vld_i(key_vld_i), .key_i(key_i),
        .s_vld_i(s_vld_i), .s_rdy_o(s_rdy_o), .s_type_i(s_type_i),
        .s_last_i(s_last_i), .s_data_i(s_data_i),
        .gcm_key_vld_o(gcm_key_vld_o), .gcm_key_o(gcm_key_o),
        .gcm_iv_vld_o(gcm_iv_vld_o), .gcm_aad_vld_o(gcm_aad_vld_o),
        .gcm_data_vld_o(gcm_data_vld_o), .gcm_end_o(gcm_end_o),
        .gcm_data_o(gcm_data_o), .gcm_dvld_i(gcm_dvld_i),
        .gcm_tag_vld_i(gcm_tag_vld_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Event log sampled mid-cycle; a pulse longer than one cycle logs twice
    always @(negedge clk) begin
        if (log_en) begin
            if (gcm_key_vld_o)  ev_q.push_back(ev_t'{K_KEY, gcm_key_o, cyc});
            if (gcm_iv_vld_o)   ev_q.push_back(ev_t'{K_IV, gcm_data_o, cyc});
            if (gcm_aad_vld_o)  ev_q.push_back(ev_t'{K_AAD, gcm_data_o, cyc});
            if (gcm_data_vld_o) ev_q.push_back(ev_t'{K_DATA, gcm_data_o, cyc});
            if (gcm_end_o)      ev_q.push_back(ev_t'{K_END, '0, cyc});
            if (done_o)         ev_q.push_back(ev_t'{K_DONE, '0, cyc});
            if (err_o)          ev_q.push_back(ev_t'{K_ERR, '0, cyc});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void push_exp(input int k, input logic [127:0] d);
        exp_q.push_back(ev_t'{k, d, 0});
    endfunction

    function automatic int first_diff();
        int n;
        n = (ev_q.size() > exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= ev_q.size() || i >= exp_q.size()) return i;
            if (ev_q[i].kind != exp_q[i].kind || ev_q[i].data !== exp_q[i].data) return i;
        end
        return -1;
    endfunction

    function automatic int act_kind(input int i);
        return (i >= 0 && i < ev_q.size()) ? ev_q[i].kind : -1;
    endfunction

    function automatic int exp_kind(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i].kind : -1;
    endfunction

    // Reference model: walks the message by the ordering rules and lists the
    // events the core interface should show. Returns 1 if the message ends.
    function automatic int model_msg(input int dvld_n);
        int strobes;
        bit seen_data;
        strobes = 0;
        seen_data = 1'b0;
        exp_q.delete();
        push_exp(K_IV, msg_q[0].data);
        if (msg_q[0].last) begin
            push_exp(K_END, '0);
            push_exp((dvld_n == 0) ? K_DONE : K_ERR, '0);
            return 1;
        end
        for (int i = 1; i < msg_q.size(); i++) begin
            if (msg_q[i].typ == 2'b11) begin
                push_exp(K_ERR, '0);
                continue;
            end
            if (msg_q[i].typ == 2'b00 || (msg_q[i].typ == 2'b01 && seen_data)) begin
                push_exp(K_ERR, '0);
                return 0;
            end
            push_exp((msg_q[i].typ == 2'b01) ? K_AAD : K_DATA, msg_q[i].data);
            strobes++;
            if (msg_q[i].typ == 2'b10) seen_data = 1'b1;
            if (msg_q[i].last) begin
                push_exp(K_END, '0);
                push_exp((dvld_n == strobes) ? K_DONE : K_ERR, '0);
                return 1;
            end
        end
        return 0;
    endfunction

    task automatic gen_msg(input int n_aad, input int n_data, input int rsv_at, input int viol);
        blk_t body[$];
        msg_q.delete();
        for (int i = 0; i < n_aad; i++)  body.push_back(blk_t'{2'b01, 1'b0, rnd128()});
        for (int i = 0; i < n_data; i++) body.push_back(blk_t'{2'b10, 1'b0, rnd128()});
        if (viol == 1)      body.push_back(blk_t'{2'b01, 1'b0, rnd128()});
        else if (viol == 2) body.push_back(blk_t'{2'b00, 1'b0, rnd128()});
        else if (body.size() > 0) body[body.size()-1].last = 1'b1;
        if (rsv_at >= 0 && rsv_at < body.size()) body.insert(rsv_at, blk_t'{2'b11, 1'b0, rnd128()});
        msg_q.push_back(blk_t'{2'b00, (body.size() == 0 && viol == 0), rnd128()});
        foreach (body[i]) msg_q.push_back(body[i]);
    endtask

    task automatic send_block(input logic [1:0] typ, input logic last, input logic [127:0] data);
        int n;
        n = 0;
        s_vld_i = 1'b1; s_type_i = typ; s_last_i = last; s_data_i = data;
        while (s_rdy_o !== 1'b1 && n < 200) begin tick(); n++; end
        if (s_rdy_o !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_block: s_rdy_o=%b after %0d cycles, required 1", s_rdy_o, n);
        end else begin
            tick();
        end
        s_vld_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({gcm_key_vld_o, gcm_iv_vld_o, gcm_aad_vld_o, gcm_data_vld_o, gcm_end_o,
             busy_o, done_o, err_o, s_rdy_o} !== 9'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 000000000",
                     {gcm_key_vld_o, gcm_iv_vld_o, gcm_aad_vld_o, gcm_data_vld_o, gcm_end_o,
                      busy_o, done_o, err_o, s_rdy_o});
        end
        total++;
        if (gcm_data_o !== '0 || gcm_key_o !== '0) begin
            bad++;
            $display("FAIL reset_buses: data=%h key=%h required 0", gcm_data_o, gcm_key_o);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        total++;
        if (s_rdy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_key_rdy: s_rdy_o=%b required 0", s_rdy_o);
        end
    endtask

    task automatic test_key();
        logic [127:0] k;
        int n;
        k = rnd128();
        key_i = k; key_vld_i = 1'b1;
        tick();
        key_vld_i = 1'b0;
        total++;
        if (gcm_key_vld_o !== 1'b1 || gcm_key_o !== k) begin
            bad++;
            $display("FAIL key_strobe: vld=%b key=%h required 1 %h", gcm_key_vld_o, gcm_key_o, k);
        end
        tick();
        n = 1;
        total++;
        if (gcm_key_vld_o !== 1'b0) begin
            bad++;
            $display("FAIL key_pulse_width: vld=%b required 0", gcm_key_vld_o);
        end
        while (s_rdy_o !== 1'b1 && n < 100) begin tick(); n++; end
        total++;
        if (n != KEY_WAIT) begin
            bad++;
            $display("FAIL key_wait: s_rdy_o rose after %0d cycles, required %0d", n, KEY_WAIT);
        end
    endtask

    task automatic test_idle_errors();
        int d;
        ev_q.delete(); exp_q.delete();
        log_en = 1'b1;
        send_block(2'b10, 1'b0, rnd128());
        total++;
        if (busy_o !== 1'b0 || s_rdy_o !== 1'b1) begin
            bad++;
            $display("FAIL idle_drop_state: busy=%b rdy=%b required 0 1", busy_o, s_rdy_o);
        end
        send_block(2'b11, 1'b1, rnd128());
        gcm_tag_vld_i = 1'b1;
        tick();
        gcm_tag_vld_i = 1'b0;
        repeat (3) tick();
        push_exp(K_ERR, '0);
        push_exp(K_ERR, '0);
        d = first_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL idle_errors_log: event %0d kind=%0d required=%0d (count %0d required %0d)",
                     d, act_kind(d), exp_kind(d), ev_q.size(), exp_q.size());
        end
    endtask

    task automatic test_messages();
        int na, nd, rs, vi, dv, ended, n, d;
        for (int m = 0; m < 18; m++) begin
            case (m)
                0: begin na = 2; nd = 3; rs = -1; vi = 0; dv = 5; end
                1: begin na = 0; nd = 1; rs = -1; vi = 1; dv = 0; end
                2: begin na = 0; nd = 0; rs = -1; vi = 0; dv = 0; end
                3: begin na = 1; nd = 2; rs = -1; vi = 0; dv = 2; end
                4: begin na = 1; nd = 1; rs = 1;  vi = 0; dv = 2; end
                5: begin na = 2; nd = 0; rs = -1; vi = 2; dv = 0; end
                default: begin
                    na = $urandom_range(0, 3);
                    nd = $urandom_range(0, 4);
                    rs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
                    vi = 0;
                    if ($urandom_range(0, 4) == 0) vi = (nd > 0) ? 1 : 2;
                    dv = na + nd;
                    if ($urandom_range(0, 3) == 0) dv = dv + 1;
                end
            endcase
            gen_msg(na, nd, rs, vi);
            ended = model_msg(dv);
            ev_q.delete();
            log_en = 1'b1;
            foreach (msg_q[i]) send_block(msg_q[i].typ, msg_q[i].last, msg_q[i].data);
            if (ended == 0) begin
                total++;
                if (busy_o !== 1'b0) begin
                    bad++;
                    $display("FAIL msg%0d abort_busy: busy=%b required 0", m, busy_o);
                end
            end else begin
                n = 0;
                while (gcm_end_o !== 1'b1 && n < 100) begin tick(); n++; end
                if (gcm_end_o !== 1'b1) begin
                    total++; bad++;
                    $display("FAIL msg%0d end_wait: gcm_end_o=%b required 1", m, gcm_end_o);
                end
                for (int i = 0; i < dv; i++) begin
                    gcm_dvld_i = 1'b1; tick(); gcm_dvld_i = 1'b0;
                    if ($urandom_range(0, 1) == 1) tick();
                end
                gcm_tag_vld_i = 1'b1; tick(); gcm_tag_vld_i = 1'b0;
            end
            repeat (3) tick();
            total++;
            if (busy_o !== 1'b0) begin
                bad++;
                $display("FAIL msg%0d final_busy: busy=%b required 0", m, busy_o);
            end
            d = first_diff();
            total++;
            if (d != -1) begin
                bad++;
                $display("FAIL msg%0d log: event %0d kind=%0d required=%0d (count %0d required %0d)",
                         m, d, act_kind(d), exp_kind(d), ev_q.size(), exp_q.size());
            end
            if (ev_q.size() >= 2) begin
                total++;
                if (ev_q[1].cyc - ev_q[0].cyc != int'(IV_GAP) + 1) begin
                    bad++;
                    $display("FAIL msg%0d iv_gap: next event %0d cycles after IV, required %0d",
                             m, ev_q[1].cyc - ev_q[0].cyc, IV_GAP + 1);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int n, d;
        gen_msg(1, 1, -1, 0);
        void'(model_msg(-1));
        ev_q.delete();
        log_en = 1'b1;
        foreach (msg_q[i]) send_block(msg_q[i].typ, msg_q[i].last, msg_q[i].data);
        n = 0;
        while (err_o !== 1'b1 && n < int'(TAG_TO) + 20) begin tick(); n++; end
        repeat (3) tick();
        d = first_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL timeout_log: event %0d kind=%0d required=%0d (count %0d required %0d)",
                     d, act_kind(d), exp_kind(d), ev_q.size(), exp_q.size());
        end
        total++;
        if (ev_q.size() != 5 || ev_q[4].cyc - ev_q[3].cyc != int'(TAG_TO)) begin
            bad++;
            $display("FAIL timeout_delay: err %0d cycles after end, required %0d",
                     (ev_q.size() == 5) ? ev_q[4].cyc - ev_q[3].cyc : -1, TAG_TO);
        end
    endtask

    task automatic test_hold_and_reset();
        logic [127:0] iv, dd, a2, d2;
        int n, viol, d;
        iv = rnd128(); dd = rnd128();
        ev_q.delete(); exp_q.delete();
        log_en = 1'b1;
        send_block(2'b00, 1'b0, iv);
        s_vld_i = 1'b1; s_type_i = 2'b10; s_last_i = 1'b0; s_data_i = rnd128();
        total++;
        if (s_rdy_o !== 1'b0) begin
            bad++;
            $display("FAIL hold_gap_rdy: s_rdy_o=%b required 0", s_rdy_o);
        end
        send_block(2'b10, 1'b1, dd);
        s_vld_i = 1'b1; s_type_i = 2'b10; s_last_i = 1'b0; s_data_i = rnd128();
        n = 0;
        while (gcm_end_o !== 1'b1 && n < 20) begin tick(); n++; end
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            if (s_rdy_o !== 1'b0) viol++;
            key_vld_i = (i == 3);
            key_i = rnd128();
            tick();
        end
        key_vld_i = 1'b0;
        s_vld_i = 1'b0;
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL hold_wait_rdy: s_rdy_o high in %0d cycles, required 0", viol);
        end
        gcm_dvld_i = 1'b1; tick(); gcm_dvld_i = 1'b0;
        gcm_tag_vld_i = 1'b1; tick(); gcm_tag_vld_i = 1'b0;
        repeat (3) tick();
        push_exp(K_IV, iv); push_exp(K_DATA, dd); push_exp(K_END, '0);
        push_exp(K_ERR, '0); push_exp(K_DONE, '0);
        d = first_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL hold_log: event %0d kind=%0d required=%0d (count %0d required %0d)",
                     d, act_kind(d), exp_kind(d), ev_q.size(), exp_q.size());
        end

        iv = rnd128(); a2 = rnd128(); d2 = rnd128();
        ev_q.delete(); exp_q.delete();
        send_block(2'b00, 1'b0, iv);
        send_block(2'b01, 1'b0, a2);
        send_block(2'b10, 1'b0, d2);
        s_vld_i = 1'b1; s_type_i = 2'b10; s_last_i = 1'b1; s_data_i = rnd128();
        rst_n = 1'b0;
        tick();
        total++;
        if ({gcm_key_vld_o, gcm_iv_vld_o, gcm_aad_vld_o, gcm_data_vld_o, gcm_end_o,
             busy_o, done_o, err_o, s_rdy_o} !== 9'b0 || gcm_data_o !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: flags=%b data=%h required all 0",
                     {gcm_key_vld_o, gcm_iv_vld_o, gcm_aad_vld_o, gcm_data_vld_o, gcm_end_o,
                      busy_o, done_o, err_o, s_rdy_o}, gcm_data_o);
        end
        tick();
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < int'(KEY_WAIT) + 4; i++) begin
            tick();
            if (s_rdy_o !== 1'b0 || busy_o !== 1'b0) viol++;
        end
        s_vld_i = 1'b0;
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL midreset_key_cleared: rdy/busy high in %0d cycles, required 0", viol);
        end
        push_exp(K_IV, iv); push_exp(K_AAD, a2); push_exp(K_DATA, d2);
        d = first_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL midreset_log: event %0d kind=%0d required=%0d (count %0d required %0d)",
                     d, act_kind(d), exp_kind(d), ev_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_key();
        test_idle_errors();
        test_messages();
        test_timeout();
        test_hold_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
